// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared constants and receiver state encoding for the usb serial link
package usb_pkg;

    localparam logic [7:0] USB_SYNC_BYTE = 8'h01;
    localparam int         USB_MAX_LEN   = 64;
    localparam int         USB_HUNT_MAX  = 255;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_HUNT,
        RX_DATA,
        RX_DONE,
        RX_DRAIN
    } rx_state_t;

endpackage

// File: rtl/usb_sipo.sv
// rtl/usb_sipo.sv - MSB-first serial-to-parallel shifter with 3-bit bit counter
module usb_sipo (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic       din,
    output logic [7:0] nxt,
    output logic [2:0] bitcnt,
    output logic       byte_done
);

    // Only seven bits are stored; the eighth is the incoming din itself.
    logic [6:0] sr;

    assign nxt       = {sr, din};
    assign byte_done = shift && (bitcnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr     <= '0;
            bitcnt <= '0;
        end else if (shift) begin
            sr     <= nxt[6:0];
            bitcnt <= bitcnt + 3'd1;
        end
    end

endmodule

// File: rtl/usb_rxf.sv
// rtl/usb_rxf.sv - serial frame receiver; define USB_RXF_CHK_EN for trailing XOR checksum
module usb_rxf
    import usb_pkg::*;
#(
    parameter logic [7:0] SYNC_DATA = USB_SYNC_BYTE,
    parameter int         MAX_LEN   = USB_MAX_LEN,
    parameter int         HUNT_MAX  = USB_HUNT_MAX,
    parameter int         LEN_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic             din,
    output logic [7:0]       dout,
    output logic             dv,
    output logic             sof,
    output logic             eof,
    output logic [LEN_W-1:0] len,
    output logic             err,
    output logic             chk_ok
);

    localparam int HW = $clog2(HUNT_MAX + 1);

    rx_state_t     state, state_n;
    logic [HW-1:0] huntcnt;
    logic [7:0]    nxt;
    logic [2:0]    bitcnt;
    logic          byte_done;
    logic          armed;
    logic          full;

    logic sipo_clr, sipo_shift, hunt_clr, hunt_inc;
    logic start, accept, err_set, eof_set;

    usb_sipo u_sipo (
        .clk       (clk),
        .rst       (rst),
        .clear     (sipo_clr),
        .shift     (sipo_shift),
        .din       (din),
        .nxt       (nxt),
        .bitcnt    (bitcnt),
        .byte_done (byte_done)
    );

`ifdef USB_RXF_CHK_EN
    logic [7:0] xacc;
    logic       have_byte;
    // len trails the byte count by one so the checksum byte is never counted.
    assign full = have_byte && (len == LEN_W'(MAX_LEN));
`else
    assign full = (len == LEN_W'(MAX_LEN));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        sipo_clr   = 1'b0;
        sipo_shift = 1'b0;
        hunt_clr   = 1'b0;
        hunt_inc   = 1'b0;
        start      = 1'b0;
        accept     = 1'b0;
        err_set    = 1'b0;
        eof_set    = 1'b0;
        case (state)
            RX_IDLE: begin
                // armed gates out the tail of a frame interrupted by reset.
                if (fire && armed) begin
                    state_n  = RX_HUNT;
                    sipo_clr = 1'b1;
                    hunt_clr = 1'b1;
                end
            end
            RX_HUNT: begin
                if (!fire) begin
                    state_n = RX_IDLE;
                end else begin
                    sipo_shift = 1'b1;
                    hunt_inc   = 1'b1;
                    if (nxt == SYNC_DATA && huntcnt >= HW'(7)) begin
                        state_n  = RX_DATA;
                        start    = 1'b1;
                        sipo_clr = 1'b1;
                    end else if (huntcnt == HW'(HUNT_MAX)) begin
                        state_n = RX_DRAIN;
                        err_set = 1'b1;
                        eof_set = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (!fire) begin
                    state_n = RX_DONE;
                    err_set = (bitcnt != 3'd0);
                end else begin
                    sipo_shift = 1'b1;
                    if (byte_done) begin
                        if (full) begin
                            state_n = RX_DRAIN;
                            err_set = 1'b1;
                            eof_set = 1'b1;
                        end else begin
                            accept = 1'b1;
                        end
                    end
                end
            end
            RX_DONE: begin
                eof_set = 1'b1;
                state_n = RX_IDLE;
            end
            RX_DRAIN: begin
                if (!fire) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            huntcnt <= '0;
            armed   <= 1'b0;
            dout    <= '0;
            dv      <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
            len     <= '0;
            err     <= 1'b0;
        end else begin
            if (!fire) armed <= 1'b1;
            if (hunt_clr)      huntcnt <= '0;
            else if (hunt_inc) huntcnt <= huntcnt + HW'(1);
            dv  <= accept;
            sof <= start;
            eof <= eof_set;
            if (accept) dout <= nxt;
            if (start) begin
                len <= '0;
                err <= 1'b0;
            end else begin
`ifdef USB_RXF_CHK_EN
                if (accept && have_byte) len <= len + LEN_W'(1);
`else
                if (accept) len <= len + LEN_W'(1);
`endif
                if (err_set) err <= 1'b1;
            end
        end
    end

`ifdef USB_RXF_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xacc      <= '0;
            have_byte <= 1'b0;
            chk_ok    <= 1'b0;
        end else if (start) begin
            xacc      <= '0;
            have_byte <= 1'b0;
            chk_ok    <= 1'b0;
        end else begin
            if (accept) begin
                xacc      <= xacc ^ nxt;
                have_byte <= 1'b1;
            end
            // Only a clean end through DONE can pass; timeout and overflow force 0.
            if (eof_set) chk_ok <= (state == RX_DONE) && (xacc == 8'h00) && !err;
        end
    end
`else
    assign chk_ok = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rxf.sv
// tb/tb_usb_rxf.sv - scoreboard bench for usb_rxf with directed frames
module tb_usb_rxf;

`ifdef USB_RXF_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int       kind;   // 0 sof, 1 dv, 2 eof
        logic [7:0] data;
        int       len;
        bit       err;
        bit       chk;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, fire, din;
    logic [7:0] dout;
    logic       dv, sof, eof, err, chk_ok;
    logic [6:0] len;

    int  n_vec = 0;
    int  n_bad = 0;
    ev_t q[$];

    always #5 clk = ~clk;

    usb_rxf #(.MAX_LEN(4), .HUNT_MAX(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .fire   (fire),
        .din    (din),
        .dout   (dout),
        .dv     (dv),
        .sof    (sof),
        .eof    (eof),
        .len    (len),
        .err    (err),
        .chk_ok (chk_ok)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_len(input int n);
        if (CHK) return (n > 0) ? n - 1 : 0;
        return n;
    endfunction

    task automatic push(input int kind, input logic [7:0] data, input int l, input bit e, input bit c);
        ev_t ev;
        ev.kind = kind; ev.data = data; ev.len = l; ev.err = e; ev.chk = c;
        q.push_back(ev);
    endtask

    task automatic tick(input logic f, input logic d);
        fire = f;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(1'b1, b[i]);
    endtask

    task automatic send_head();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        send_byte(8'h01);
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        check({name, "_events_left"}, q.size(), 0);
        q.delete();
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (sof || dv || eof) begin
            check("pulse_overlap", int'(sof) + int'(dv) + int'(eof), 1);
            kind = eof ? 2 : (dv ? 1 : 0);
            if (q.size() == 0) begin
                check("unexpected_event_kind", kind, -1);
            end else begin
                e = q.pop_front();
                check("event_kind", kind, e.kind);
                if (e.kind == kind) begin
                    case (kind)
                        0: begin
                            check("sof_len", int'(len), 0);
                            check("sof_err", int'(err), 0);
                        end
                        1: check("dv_dout", int'(dout), int'(e.data));
                        default: begin
                            check("eof_len", int'(len), e.len);
                            check("eof_err", int'(err), int'(e.err));
                            check("eof_chk_ok", int'(chk_ok), int'(e.chk));
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        rst = 1'b1; fire = 1'b0; din = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rst_dout", int'(dout), 0);
        check("rst_flags", {dv, sof, eof, err, chk_ok}, 0);
        check("rst_len", int'(len), 0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // basic frame
        push(0, 8'h00, 0, 0, 0);
        push(1, 8'hA5, 0, 0, 0);
        push(1, 8'h3C, 0, 0, 0);
        push(2, 8'h00, exp_len(2), 0, 0);
        send_head(); send_byte(8'hA5); send_byte(8'h3C);
        settle("basic");

        // truncated last byte
        push(0, 8'h00, 0, 0, 0);
        push(1, 8'h5A, 0, 0, 0);
        push(2, 8'h00, exp_len(1), 1, 0);
        send_head(); send_byte(8'h5A);
        tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
        settle("trunc");

        // sync timeout; a valid-looking header afterwards is ignored in DRAIN
        push(2, 8'h00, exp_len(1), 1, 0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        send_head(); send_byte(8'h77);
        check("timeout_err", int'(err), 1);
        settle("timeout");

        // overflow at MAX_LEN=4
        push(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < (CHK ? 5 : 4); i++) push(1, 8'h10 + 8'(i), 0, 0, 0);
        push(2, 8'h00, 4, 1, 0);
        send_head();
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        settle("overflow");

        // reset mid-frame, then a clean frame after fire toggles
        push(0, 8'h00, 0, 0, 0);
        push(1, 8'h11, 0, 0, 0);
        push(1, 8'h22, 0, 0, 0);
        send_head(); send_byte(8'h11); send_byte(8'h22);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        check("midrst_dout", int'(dout), 0);
        check("midrst_flags", {dv, sof, eof, err, chk_ok}, 0);
        check("midrst_len", int'(len), 0);
        send_head(); send_byte(8'h44);
        check("midrst_events_left", q.size(), 0);
        tick(1'b0, 1'b0);
        push(0, 8'h00, 0, 0, 0);
        push(1, 8'h55, 0, 0, 0);
        push(1, 8'h66, 0, 0, 0);
        push(2, 8'h00, exp_len(2), 0, 0);
        send_head(); send_byte(8'h55); send_byte(8'h66);
        settle("after_rst");

        // checksum good then bad
        push(0, 8'h00, 0, 0, 0);
        push(1, 8'h12, 0, 0, 0);
        push(1, 8'h34, 0, 0, 0);
        push(1, 8'h26, 0, 0, 0);
        push(2, 8'h00, exp_len(3), 0, CHK);
        send_head(); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
        settle("chk_good");
        push(0, 8'h00, 0, 0, 0);
        push(1, 8'h12, 0, 0, 0);
        push(1, 8'h34, 0, 0, 0);
        push(1, 8'h27, 0, 0, 0);
        push(2, 8'h00, exp_len(3), 0, 0);
        send_head(); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
        settle("chk_bad");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
